// File: rtl/enemy_grid_mover_if.sv
// Bus between the tick sequencer / grid RAM and the enemy movement engine.
// The engine uses the slave view; the sequencer side uses the master view.
interface enemy_grid_mover_if #(
  parameter int XW = 6,
  parameter int YW = 5,
  parameter int CW = 3
);
  logic            start;
  logic            done;
  logic            busy;
  logic [XW-1:0]   grid_x;
  logic [YW-1:0]   grid_y;
  logic [CW-1:0]   grid_out;
  logic            grid_write;
  logic [CW-1:0]   grid_in;
  logic [YW+XW-1:0] moves;

  modport master (
    output start, grid_out,
    input  done, busy, grid_x, grid_y, grid_write, grid_in, moves
  );

  modport slave (
    input  start, grid_out,
    output done, busy, grid_x, grid_y, grid_write, grid_in, moves
  );
endinterface

// File: rtl/enemy_grid_mover.sv
// Raster-scans the level grid and steps each enemy into an adjacent empty cell.
// Optional player-chasing first direction: define ENEMY_GRID_MOVER_CHASE_EN.
module enemy_grid_mover #(
  parameter int GRID_W       = 40,
  parameter int GRID_H       = 30,
  parameter int XW           = 6,
  parameter int YW           = 5,
  parameter int CW           = 3,
  parameter int EMPTY_CODE   = 0,
  parameter int ENEMY_CODE_A = 4,
  parameter int ENEMY_CODE_B = 5,
  parameter int MOVE_PERIOD  = 200000,
  parameter int MAX_TRIES    = 4
) (
  input  logic          clock,
  input  logic          reset,
`ifdef ENEMY_GRID_MOVER_CHASE_EN
  input  logic [XW-1:0] player_x,
  input  logic [YW-1:0] player_y,
`endif
  enemy_grid_mover_if.slave bus
);

  localparam int CNTW = (MOVE_PERIOD < 1) ? 1 : $clog2(MOVE_PERIOD + 1);
  localparam logic [CNTW-1:0] PERIOD = CNTW'(MOVE_PERIOD);
  localparam logic [XW-1:0]   X_LAST = XW'(GRID_W - 1);
  localparam logic [YW-1:0]   Y_LAST = YW'(GRID_H - 1);
  localparam logic [CW-1:0]   EMPTY  = CW'(EMPTY_CODE);
  localparam logic [CW-1:0]   CODE_A = CW'(ENEMY_CODE_A);
  localparam logic [CW-1:0]   CODE_B = CW'(ENEMY_CODE_B);
  localparam logic [2:0]      TRIES  = 3'(MAX_TRIES);

  typedef enum logic [3:0] {
    S_IDLE, S_GATE, S_SCAN_RD, S_SCAN_WAIT, S_SCAN_EVAL, S_PICK,
    S_NB_RD, S_NB_WAIT, S_NB_EVAL, S_NEXT_DIR, S_WR_NEW, S_WR_OLD,
    S_RETAG, S_ADVANCE, S_FLIP, S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [XW-1:0]       cur_x_reg, cur_y_dummy_unused_x;
  logic [YW-1:0]       cur_y_reg;
  logic [XW-1:0]       nb_x_reg;
  logic [YW-1:0]       nb_y_reg;
  logic [1:0]          dir_reg;
  logic [2:0]          tries_reg;
  logic                tag_reg;
  logic [CNTW-1:0]     cnt_reg;
  logic [7:0]          lfsr_reg;
  logic [YW+XW-1:0]    moves_reg;
  logic [XW-1:0]       addr_x_reg;
  logic [YW-1:0]       addr_y_reg;
  logic                write_reg;
  logic [CW-1:0]       wdata_reg;
  logic                done_reg;
  logic                busy_reg;

  logic [CW-1:0]       eligible, written;
  logic [XW-1:0]       pick_x, adv_x, scan_x;
  logic [YW-1:0]       pick_y, adv_y, scan_y;
  logic                pick_oob, at_last, row_end;
  logic [1:0]          base_dir;
  logic                lfsr_fb;

  assign cur_y_dummy_unused_x = '0;

  // Tag 0 moves A enemies and leaves them as B; tag 1 does the reverse.
  assign eligible = tag_reg ? CODE_B : CODE_A;
  assign written  = tag_reg ? CODE_A : CODE_B;

  assign row_end = (cur_x_reg == X_LAST);
  assign at_last = row_end && (cur_y_reg == Y_LAST);
  assign adv_x   = row_end ? '0 : cur_x_reg + XW'(1);
  assign adv_y   = row_end ? cur_y_reg + YW'(1) : cur_y_reg;
  assign scan_x  = (state_reg == S_GATE) ? '0 : adv_x;
  assign scan_y  = (state_reg == S_GATE) ? '0 : adv_y;
  assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

`ifdef ENEMY_GRID_MOVER_CHASE_EN
  logic signed [XW:0] dx;
  logic signed [YW:0] dy;
  logic [XW:0]        adx;
  logic [YW:0]        ady;

  always_comb begin
    dx  = $signed({1'b0, player_x}) - $signed({1'b0, cur_x_reg});
    dy  = $signed({1'b0, player_y}) - $signed({1'b0, cur_y_reg});
    adx = dx[XW] ? -dx : dx;
    ady = dy[YW] ? -dy : dy;
    base_dir = lfsr_reg[1:0];
    if (adx != '0 || ady != '0) begin
      // Larger axis distance wins; equal distances prefer the x axis.
      if (int'(adx) >= int'(ady)) base_dir = dx[XW] ? 2'd3 : 2'd1;
      else                        base_dir = dy[YW] ? 2'd0 : 2'd2;
    end
  end
`else
  assign base_dir = lfsr_reg[1:0];
`endif

  always_comb begin
    pick_x   = cur_x_reg;
    pick_y   = cur_y_reg;
    pick_oob = 1'b0;
    case (dir_reg)
      2'd0: begin
        pick_oob = (cur_y_reg == '0);
        pick_y   = cur_y_reg - YW'(1);
      end
      2'd1: begin
        pick_oob = (cur_x_reg == X_LAST);
        pick_x   = cur_x_reg + XW'(1);
      end
      2'd2: begin
        pick_oob = (cur_y_reg == Y_LAST);
        pick_y   = cur_y_reg + YW'(1);
      end
      default: begin
        pick_oob = (cur_x_reg == '0);
        pick_x   = cur_x_reg - XW'(1);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (bus.start) state_next = S_GATE;
      S_GATE:      state_next = (cnt_reg == '0) ? S_SCAN_RD : S_DONE;
      S_SCAN_RD:   state_next = S_SCAN_WAIT;
      S_SCAN_WAIT: state_next = S_SCAN_EVAL;
      S_SCAN_EVAL: state_next = (bus.grid_out == eligible) ? S_PICK : S_ADVANCE;
      S_PICK:      state_next = pick_oob ? S_NEXT_DIR : S_NB_RD;
      S_NB_RD:     state_next = S_NB_WAIT;
      S_NB_WAIT:   state_next = S_NB_EVAL;
      S_NB_EVAL:   state_next = (bus.grid_out == EMPTY) ? S_WR_NEW : S_NEXT_DIR;
      S_NEXT_DIR:  state_next = ((tries_reg + 3'd1) == TRIES) ? S_RETAG : S_PICK;
      S_WR_NEW:    state_next = S_WR_OLD;
      S_WR_OLD:    state_next = S_ADVANCE;
      S_RETAG:     state_next = S_ADVANCE;
      S_ADVANCE:   state_next = at_last ? S_FLIP : S_SCAN_RD;
      S_FLIP:      state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Bus outputs are registered from the state being entered, so the address
  // and strobe are presented for the whole of the state that owns them.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_x_reg  <= '0;
      cur_y_reg  <= '0;
      nb_x_reg   <= '0;
      nb_y_reg   <= '0;
      dir_reg    <= '0;
      tries_reg  <= '0;
      tag_reg    <= 1'b0;
      cnt_reg    <= PERIOD;
      lfsr_reg   <= 8'hA5;
      moves_reg  <= '0;
      addr_x_reg <= '0;
      addr_y_reg <= '0;
      write_reg  <= 1'b0;
      wdata_reg  <= '0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_fb};

      if (state_reg == S_GATE && cnt_reg == '0) cnt_reg <= PERIOD;
      else if (cnt_reg != '0)                   cnt_reg <= cnt_reg - CNTW'(1);

      case (state_reg)
        S_GATE: begin
          if (cnt_reg == '0) begin
            moves_reg <= '0;
            cur_x_reg <= '0;
            cur_y_reg <= '0;
          end
        end
        S_SCAN_EVAL: begin
          if (bus.grid_out == eligible) begin
            tries_reg <= '0;
            dir_reg   <= base_dir;
          end
        end
        S_PICK: begin
          nb_x_reg <= pick_x;
          nb_y_reg <= pick_y;
        end
        S_NEXT_DIR: begin
          tries_reg <= tries_reg + 3'd1;
          dir_reg   <= dir_reg + 2'd1;
        end
        S_WR_OLD:  moves_reg <= moves_reg + (YW+XW)'(1);
        S_ADVANCE: begin
          if (!at_last) begin
            cur_x_reg <= adv_x;
            cur_y_reg <= adv_y;
          end
        end
        S_FLIP:    tag_reg <= ~tag_reg;
        default: ;
      endcase

      done_reg  <= (state_reg == S_DONE);
      busy_reg  <= (state_next != S_IDLE);
      write_reg <= (state_next == S_WR_NEW) || (state_next == S_WR_OLD) ||
                   (state_next == S_RETAG);

      case (state_next)
        S_SCAN_RD: begin
          addr_x_reg <= scan_x;
          addr_y_reg <= scan_y;
        end
        S_NB_RD: begin
          addr_x_reg <= pick_x;
          addr_y_reg <= pick_y;
        end
        S_WR_NEW: begin
          addr_x_reg <= nb_x_reg;
          addr_y_reg <= nb_y_reg;
          wdata_reg  <= written;
        end
        S_WR_OLD: begin
          addr_x_reg <= cur_x_reg;
          addr_y_reg <= cur_y_reg;
          wdata_reg  <= EMPTY;
        end
        S_RETAG: begin
          addr_x_reg <= cur_x_reg;
          addr_y_reg <= cur_y_reg;
          wdata_reg  <= written;
        end
        default: ;
      endcase
    end
  end

  assign bus.done       = done_reg;
  assign bus.busy       = busy_reg;
  assign bus.grid_x     = addr_x_reg | cur_y_dummy_unused_x;
  assign bus.grid_y     = addr_y_reg;
  assign bus.grid_write = write_reg;
  assign bus.grid_in    = wdata_reg;
  assign bus.moves      = moves_reg;

endmodule

// File: tb/tb_enemy_grid_mover.sv
// Directed bench: 4x3 walled grid in a 2-cycle-latency RAM model, one pass per vector.
module tb_enemy_grid_mover;

  localparam int GW = 4;
  localparam int GH = 3;
  localparam int PERIOD = 100;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  enemy_grid_mover_if bus ();

`ifdef ENEMY_GRID_MOVER_CHASE_EN
  logic [5:0] player_x = 6'd3;
  logic [4:0] player_y = 5'd1;
`endif

  enemy_grid_mover #(
    .GRID_W(GW), .GRID_H(GH), .MOVE_PERIOD(PERIOD), .MAX_TRIES(4)
  ) dut (
    .clock(clk),
    .reset(rst),
`ifdef ENEMY_GRID_MOVER_CHASE_EN
    .player_x(player_x),
    .player_y(player_y),
`endif
    .bus(bus)
  );

  // RAM model: address seen in cycle t, data valid in cycle t+2.
  logic [2:0] mem [GW*GH];
  logic [2:0] rd1;
  logic       ld_en = 1'b0;
  int         ld_idx = 0;
  logic [2:0] ld_val = '0;

  wire addr_ok = (bus.grid_x < 6'(GW)) && (bus.grid_y < 5'(GH));
  wire [31:0] addr_idx = 32'(bus.grid_y) * GW + 32'(bus.grid_x);

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (bus.grid_write && addr_ok) mem[addr_idx] <= bus.grid_in;
    rd1 <= addr_ok ? mem[addr_idx] : 3'd7;
    bus.grid_out <= rd1;
  end

  initial bus.start = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_cell(input int x, input int y, input int v);
    ld_en = 1'b1;
    ld_idx = y * GW + x;
    ld_val = 3'(v);
    tick();
    ld_en = 1'b0;
  endtask

  task automatic init_grid;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        load_cell(x, y, (x == 0 || y == 0 || x == GW-1 || y == GH-1) ? 1 : 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    check({tag, "_rst_done"}, int'(bus.done), 0);
    check({tag, "_rst_busy"}, int'(bus.busy), 0);
    check({tag, "_rst_write"}, int'(bus.grid_write), 0);
    check({tag, "_rst_addr"}, int'(bus.grid_x) + int'(bus.grid_y) + int'(bus.grid_in), 0);
    check({tag, "_rst_moves"}, int'(bus.moves), 0);
    rst = 1'b0;
  endtask

  // Issue one start pulse and follow the pass to its done pulse.
  task automatic run_pass(output int lat, output int writes, output int bad, output bit seen);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    writes = 0;
    bad = 0;
    while (bus.done !== 1'b1 && lat < LIMIT) begin
      if (bus.grid_write) writes++;
      if (!addr_ok) bad++;
      tick();
      lat++;
    end
    seen = (bus.done === 1'b1);
  endtask

  typedef struct {
    bit do_rst;
    int gap;
    int p0x, p0y, p0c;
    int p1x, p1y, p1c;
    bit skipped;
    int e_moves, e_writes, e00, e11, e21;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, writes, bad, n;
    bit seen;
    string nm;

    vecs[0] = '{1, 120, 1, 1, 4, 0, 0, -1, 0, 1, 2, 1, 0, 5};
    vecs[1] = '{0, 3,   0, 0, -1, 0, 0, -1, 1, 1, 0, 1, 0, 5};
    vecs[2] = '{0, 110, 0, 0, -1, 0, 0, -1, 0, 1, 2, 1, 4, 0};
    vecs[3] = '{1, 120, 0, 0, 4, 0, 0, -1, 0, 0, 1, 5, 0, 0};
    vecs[4] = '{0, 110, 0, 0, -1, 0, 0, -1, 0, 0, 1, 4, 0, 0};
    vecs[5] = '{1, 120, 1, 1, 4, 2, 1, 4, 0, 0, 2, 1, 5, 5};
    vecs[6] = '{0, 110, 0, 0, -1, 0, 0, -1, 0, 0, 2, 1, 4, 4};

    for (int i = 0; i < 7; i++) begin
      nm = $sformatf("v%0d", i);
      if (vecs[i].do_rst) begin
        do_reset(nm);
        init_grid();
      end
      if (vecs[i].p0c >= 0) load_cell(vecs[i].p0x, vecs[i].p0y, vecs[i].p0c);
      if (vecs[i].p1c >= 0) load_cell(vecs[i].p1x, vecs[i].p1y, vecs[i].p1c);
      repeat (vecs[i].gap) tick();
      run_pass(lat, writes, bad, seen);
      check({nm, "_done_seen"}, int'(seen), 1);
      if (vecs[i].skipped) check({nm, "_skip_latency"}, lat, 3);
      check({nm, "_moves"}, int'(bus.moves), vecs[i].e_moves);
      check({nm, "_writes"}, writes, vecs[i].e_writes);
      check({nm, "_addr_range"}, bad, 0);
      check({nm, "_cell00"}, int'(mem[0]), vecs[i].e00);
      check({nm, "_cell11"}, int'(mem[1*GW+1]), vecs[i].e11);
      check({nm, "_cell21"}, int'(mem[1*GW+2]), vecs[i].e21);
      tick();
      check({nm, "_done_one_cycle"}, int'(bus.done), 0);
      $display("vec %0d: latency=%0d writes=%0d moves=%0d cells(0,0)=%0d (1,1)=%0d (2,1)=%0d",
               i, lat, writes, bus.moves, mem[0], mem[GW+1], mem[GW+2]);
    end

    // Reset landing on the first write of a move: write commits, no done, state cleared.
    do_reset("mid");
    init_grid();
    load_cell(1, 1, 4);
    repeat (120) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("mid_busy_after_start", int'(bus.busy), 1);
    n = 0;
    while (bus.grid_write !== 1'b1 && n < LIMIT) begin
      tick();
      n++;
    end
    check("mid_wr_new_seen", int'(bus.grid_write === 1'b1), 1);
    check("mid_wr_new_x", int'(bus.grid_x), 2);
    check("mid_wr_new_code", int'(bus.grid_in), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_write_cleared", int'(bus.grid_write), 0);
    check("mid_busy_cleared", int'(bus.busy), 0);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus.done) n++;
      tick();
    end
    check("mid_no_done", n, 0);
    check("mid_cell21_committed", int'(mem[GW+2]), 5);
    check("mid_cell11_left", int'(mem[GW+1]), 4);
    run_pass(lat, writes, bad, seen);
    check("mid_counter_reload_skip", lat, 3);
    check("mid_skip_writes", writes, 0);
    $display("mid: skipped pass latency=%0d writes=%0d", lat, writes);
    repeat (110) tick();
    run_pass(lat, writes, bad, seen);
    check("mid_tag0_done", int'(seen), 1);
    check("mid_tag0_retag", int'(mem[GW+1]), 5);
    check("mid_tag0_writes", writes, 1);
    check("mid_tag0_moves", int'(bus.moves), 0);
    $display("mid: pass after reset writes=%0d moves=%0d cell(1,1)=%0d", writes, bus.moves, mem[GW+1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
